// File: rtl/tx_hs_byte_feeder.sv
// Byte-clock feeder for the TX HS FSM: buffers PPI payload bytes in a small
// show-ahead FIFO and frames the HS burst (entry, last byte, exit hold).
module tx_hs_byte_feeder #(
  parameter int DEPTH    = 8,
  parameter int PRIME    = 2,
  parameter int EXIT_CYC = 8
) (
  input  logic       TX_DDR_clk,
  input  logic       TX_rst,
  input  logic       TxRequestHS,
  input  logic [7:0] TxDataHS,
  input  logic       TxWriteHS,
  output logic       TxReadyHS,
  input  logic       TX_HS_READY,
  output logic       Enable,
  output logic [7:0] TX_BYTE_DATA,
  output logic       TX_HS_END_DATA,
  output logic       TxBusy,
  output logic       TxUnderflow
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(EXIT_CYC + 1);

  typedef enum logic [2:0] {S_IDLE, S_FILL, S_SEND, S_END, S_EXIT} state_t;

  state_t          state_q, state_d;
  logic [7:0]      mem_q [DEPTH];
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]     count_q, count_d;
  logic [CW-1:0]   exit_cnt_q, exit_cnt_d;
  logic            enable_q, enable_d;
  logic            end_q, end_d;
  logic            uflow_q, uflow_d;
  logic            full, push, pop;

  assign full      = (count_q == (AW+1)'(DEPTH));
  assign TxReadyHS = TxRequestHS & ~full & ~TX_rst &
                     (state_q == S_IDLE || state_q == S_FILL || state_q == S_SEND);
  assign push      = TxWriteHS & TxReadyHS;
  assign pop       = TX_HS_READY & (state_q == S_SEND) & (count_q != '0);

  always_comb begin
    state_d    = state_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    exit_cnt_d = exit_cnt_q;
    uflow_d    = uflow_q;
    count_d    = count_q + (AW+1)'(push) - (AW+1)'(pop);
    if (push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);

    case (state_q)
      S_IDLE: if (TxRequestHS) begin
        state_d = S_FILL;
        uflow_d = 1'b0;
      end
      S_FILL: begin
        if (count_d >= (AW+1)'(PRIME))  state_d = S_SEND;
        else if (!TxRequestHS)          state_d = (count_d != '0) ? S_SEND : S_IDLE;
      end
      S_SEND: begin
        // Drained with no more payload coming is a normal end; drained while
        // the protocol still holds the request means the burst got truncated.
        if (pop && count_q == (AW+1)'(1) && !push && !TxRequestHS) begin
          state_d = S_END;
        end else if (TX_HS_READY && count_q == '0) begin
          state_d = S_END;
          if (TxRequestHS) uflow_d = 1'b1;
        end
      end
      S_END: begin
        state_d    = S_EXIT;
        exit_cnt_d = CW'(EXIT_CYC - 1);
      end
      S_EXIT: begin
        if (exit_cnt_q == '0) state_d = S_IDLE;
        else                  exit_cnt_d = exit_cnt_q - CW'(1);
      end
      default: state_d = S_IDLE;
    endcase

    enable_d = (state_d == S_SEND) || (state_d == S_END) || (state_d == S_EXIT);
    end_d    = (state_d == S_END);
  end

  always_ff @(posedge TX_DDR_clk) begin
    if (TX_rst) begin
      state_q    <= S_IDLE;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      exit_cnt_q <= '0;
      enable_q   <= 1'b0;
      end_q      <= 1'b0;
      uflow_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      exit_cnt_q <= exit_cnt_d;
      enable_q   <= enable_d;
      end_q      <= end_d;
      uflow_q    <= uflow_d;
    end
  end

  // Storage needs no reset: the head is masked to 00 whenever count is 0.
  always_ff @(posedge TX_DDR_clk) begin
    if (push) mem_q[wr_ptr_q] <= TxDataHS;
  end

  assign TX_BYTE_DATA   = (count_q == '0) ? 8'h00 : mem_q[rd_ptr_q];
  assign Enable         = enable_q;
  assign TX_HS_END_DATA = end_q;
  assign TxBusy         = (state_q != S_IDLE);
  assign TxUnderflow    = uflow_q;
endmodule

// File: tb/tb_tx_hs_byte_feeder.sv
// Self-checking bench for tx_hs_byte_feeder: burst table plus hand-written
// corner sequences; delivered bytes are checked against a scoreboard queue.
module tb_tx_hs_byte_feeder;
  localparam int DEPTH = 8, PRIME = 2, EXIT_CYC = 8;

  logic       clk = 1'b0;
  logic       TX_rst, TxRequestHS, TxWriteHS, TX_HS_READY;
  logic [7:0] TxDataHS;
  logic       TxReadyHS, Enable, TX_HS_END_DATA, TxBusy, TxUnderflow;
  logic [7:0] TX_BYTE_DATA;

  tx_hs_byte_feeder #(.DEPTH(DEPTH), .PRIME(PRIME), .EXIT_CYC(EXIT_CYC)) dut (
    .TX_DDR_clk(clk), .TX_rst(TX_rst), .TxRequestHS(TxRequestHS),
    .TxDataHS(TxDataHS), .TxWriteHS(TxWriteHS), .TxReadyHS(TxReadyHS),
    .TX_HS_READY(TX_HS_READY), .Enable(Enable), .TX_BYTE_DATA(TX_BYTE_DATA),
    .TX_HS_END_DATA(TX_HS_END_DATA), .TxBusy(TxBusy), .TxUnderflow(TxUnderflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    int               n;
    logic [3:0][7:0]  b;
  } burst_t;

  burst_t     vecs [4];
  logic [7:0] exp_q [$];
  int         checks = 0;
  int         errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cyc();
    @(posedge clk); #1;
  endtask

  // One write attempt; en_exp < 0 skips the Enable check.
  task automatic wr(input logic [7:0] d, input bit acc, input int en_exp);
    TxRequestHS = 1'b1; TxWriteHS = 1'b1; TxDataHS = d;
    @(negedge clk);
    chk("tx_ready", TxReadyHS, acc);
    if (en_exp >= 0) chk("enable_during_fill", Enable, en_exp[0]);
    if (acc) exp_q.push_back(d);
    cyc();
  endtask

  task automatic read_bytes(input int n);
    logic [7:0] e;
    for (int i = 0; i < n; i++) begin
      TX_HS_READY = 1'b1;
      @(negedge clk);
      if (exp_q.size() == 0) begin
        e = 8'h00;
        chk("scoreboard_empty", 1, 0);
      end else e = exp_q.pop_front();
      chk("byte_data", TX_BYTE_DATA, e);
      chk("end_early", TX_HS_END_DATA, 0);
      cyc();
    end
    TX_HS_READY = 1'b0;
  endtask

  // Starts just after the last pop (or truncating) edge.
  task automatic finish_burst(input bit uf);
    int k;
    @(negedge clk);
    chk("end_pulse", TX_HS_END_DATA, 1);
    chk("underflow", TxUnderflow, uf);
    k = 0;
    while (k < 20) begin
      cyc(); @(negedge clk); k++;
      if (!Enable) break;
      chk("end_one_cycle", TX_HS_END_DATA, 0);
    end
    chk("enable_fall_delay", k, EXIT_CYC + 1);
    chk("busy_after_exit", TxBusy, 0);
    cyc();
  endtask

  task automatic run_burst(input burst_t v);
    int k;
    for (int i = 0; i < v.n; i++) wr(v.b[i], 1'b1, (i == 0) ? -1 : int'(i - 1 >= PRIME - 1));
    TxWriteHS = 1'b0; TxRequestHS = 1'b0;
    k = 0;
    @(negedge clk);
    while (!Enable && k < 4) begin cyc(); @(negedge clk); k++; end
    chk("enable_up", Enable, 1);
    cyc();
    read_bytes(v.n);
    finish_burst(1'b0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1);
  end

  initial begin
    vecs[0].n = 3; vecs[0].b = {8'h00, 8'hF0, 8'h3C, 8'hA5};
    vecs[1].n = 1; vecs[1].b = {8'h00, 8'h00, 8'h00, 8'h55};
    vecs[2].n = 4; vecs[2].b = {8'h7E, 8'h81, 8'hFF, 8'h00};
    vecs[3].n = 2; vecs[3].b = {8'h00, 8'h00, 8'hC3, 8'h01};

    TX_rst = 1'b1; TxRequestHS = 1'b1; TxWriteHS = 1'b1; TxDataHS = 8'hEE; TX_HS_READY = 1'b0;
    cyc(); cyc();
    @(negedge clk);
    chk("rst_enable", Enable, 0);
    chk("rst_data", TX_BYTE_DATA, 8'h00);
    chk("rst_end", TX_HS_END_DATA, 0);
    chk("rst_ready", TxReadyHS, 0);
    chk("rst_busy", TxBusy, 0);
    chk("rst_underflow", TxUnderflow, 0);
    cyc();
    TX_rst = 1'b0; TxRequestHS = 1'b0; TxWriteHS = 1'b0;
    cyc();

    for (int v = 0; v < 4; v++) run_burst(vecs[v]);

    // Request with no payload never enters HS.
    TxRequestHS = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cyc(); @(negedge clk);
      chk("empty_busy", TxBusy, 1);
      chk("empty_enable", Enable, 0);
    end
    cyc();
    TxRequestHS = 1'b0;
    cyc(); @(negedge clk);
    chk("empty_idle", TxBusy, 0);
    chk("empty_no_enable", Enable, 0);
    cyc();

    // Backpressure: only the first DEPTH of ten writes land.
    for (int i = 0; i < 10; i++) wr(8'(8'h20 + i), (i < DEPTH), -1);
    TxWriteHS = 1'b0;
    read_bytes(1);
    @(negedge clk);
    chk("ready_after_pop", TxReadyHS, 1);
    cyc();
    TxRequestHS = 1'b0;
    read_bytes(DEPTH - 1);
    finish_burst(1'b0);

    // Underflow: request held past the buffered payload.
    wr(8'h61, 1'b1, -1);
    wr(8'h62, 1'b1, -1);
    TxWriteHS = 1'b0;
    read_bytes(2);
    TX_HS_READY = 1'b1;
    @(negedge clk);
    chk("uflow_empty_head", TX_BYTE_DATA, 8'h00);
    cyc();
    TX_HS_READY = 1'b0; TxRequestHS = 1'b0;
    finish_burst(1'b1);
    @(negedge clk);
    chk("uflow_sticky", TxUnderflow, 1);
    cyc();
    TxRequestHS = 1'b1;
    cyc(); @(negedge clk);
    chk("uflow_cleared", TxUnderflow, 0);
    cyc();
    TxRequestHS = 1'b0;
    cyc(); cyc();

    // Reset mid-burst discards the buffer.
    wr(8'h11, 1'b1, -1);
    wr(8'h22, 1'b1, -1);
    wr(8'h33, 1'b1, -1);
    TxWriteHS = 1'b0; TX_rst = 1'b1;
    @(negedge clk);
    chk("mid_rst_enable_before", Enable, 1);
    chk("mid_rst_ready", TxReadyHS, 0);
    cyc();
    TX_rst = 1'b0; TxRequestHS = 1'b0;
    exp_q.delete();
    @(negedge clk);
    chk("mid_rst_enable", Enable, 0);
    chk("mid_rst_data", TX_BYTE_DATA, 8'h00);
    chk("mid_rst_busy", TxBusy, 0);
    cyc();
    begin
      burst_t nb;
      nb.n = 2; nb.b = {8'h00, 8'h00, 8'hBC, 8'h9A};
      run_burst(nb);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
